// File: rtl/alu_pkg.sv
// Shared command codes, FSM state encoding and default operand width
// for the BreadBoard ALU command channels.
package alu_pkg;

   localparam int DEF_WIDTH = 16;

   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_MUL = 4'd3;
   localparam logic [3:0] CMD_DIV = 4'd4;
   localparam logic [3:0] CMD_MOD = 4'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIN  = 2'd3
   } state_t;

endpackage

// File: rtl/mul_div_unit_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] trial;

   // rem_in < divisor, so the trial value is below 2*divisor and the
   // difference always fits back into WIDTH bits.
   always_comb begin
      trial   = {rem_in, bit_in};
      q_bit   = (trial >= {1'b0, divisor});
      rem_out = q_bit ? WIDTH'(trial - {1'b0, divisor}) : trial[WIDTH-1:0];
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply / divide / modulo engine with a start/busy/done
// handshake; one operand bit is processed per cycle.
module mul_div_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int RES_W = 2 * WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       command,
   input  logic [WIDTH-1:0] inputA,
   input  logic [WIDTH-1:0] inputB,
   output logic             busy,
   output logic             done,
   output logic [RES_W-1:0] result,
   output logic             error
);

   localparam int                CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt;
   logic [3:0]         cmd_r;
   logic [RES_W-1:0]   opa;
   logic [WIDTH-1:0]   opb;
   logic [RES_W-1:0]   prod;
   logic [WIDTH-1:0]   rem;
   logic               err_pend;
   logic               is_mul, is_dm;
   logic [WIDTH-1:0]   rem_nx;
   logic               q_bit;

   assign is_mul = (command == CMD_MUL);
   assign is_dm  = (command == CMD_DIV) || (command == CMD_MOD);

   // In DIV the low half of opa is the dividend; quotient bits shift in behind it.
   div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_in  (rem),
      .bit_in  (opa[WIDTH-1]),
      .divisor (opb),
      .rem_out (rem_nx),
      .q_bit   (q_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (start) begin
               if (is_mul)                      state_nx = MUL;
               else if (is_dm && inputB != '0)  state_nx = DIV;
               else                             state_nx = FIN;
            end
         end
         MUL, DIV: if (cnt == LAST) state_nx = FIN;
         FIN:      state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         error    <= 1'b0;
         cnt      <= '0;
         cmd_r    <= '0;
         opa      <= '0;
         opb      <= '0;
         prod     <= '0;
         rem      <= '0;
         err_pend <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  cmd_r    <= command;
                  opa      <= {{(RES_W-WIDTH){1'b0}}, inputA};
                  opb      <= inputB;
                  prod     <= '0;
                  rem      <= '0;
                  cnt      <= '0;
                  error    <= 1'b0;
                  busy     <= 1'b1;
                  err_pend <= !(is_mul || (is_dm && inputB != '0));
               end
            end
            MUL: begin
               prod <= prod + (opb[0] ? opa : '0);
               opa  <= opa << 1;
               opb  <= opb >> 1;
               cnt  <= cnt + 1'b1;
            end
            DIV: begin
               opa[WIDTH-1:0] <= {opa[WIDTH-2:0], q_bit};
               rem            <= rem_nx;
               cnt            <= cnt + 1'b1;
            end
            FIN: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               error <= err_pend;
               if (err_pend) begin
                  if (cmd_r == CMD_DIV)      result <= '1;
                  else if (cmd_r == CMD_MOD) result <= {{(RES_W-WIDTH){1'b0}}, opa[WIDTH-1:0]};
                  else                       result <= '0;
               end else begin
                  if (cmd_r == CMD_MUL)      result <= prod;
                  else if (cmd_r == CMD_DIV) result <= {{(RES_W-WIDTH){1'b0}}, opa[WIDTH-1:0]};
                  else                       result <= {{(RES_W-WIDTH){1'b0}}, rem};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: arithmetic results, latency,
// error paths, start-while-busy, back-to-back start and asynchronous abort.
module tb_mul_div_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  command;
   logic [15:0] inputA;
   logic [15:0] inputB;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        error;

   int n_chk  = 0;
   int n_pass = 0;
   int lat;
   int bcnt;

   mul_div_unit #(.WIDTH(16), .RES_W(32)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .command (command),
      .inputA  (inputA),
      .inputB  (inputB),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .error   (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Leaves the bench 1ns after the accepting edge E0.
   task automatic issue(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      command = c;
      inputA  = a;
      inputB  = b;
      start   = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Counts edges until done (bounded) and the cycles busy was seen high.
   task automatic wait_done(output int l, output int bc);
      l  = 0;
      bc = busy ? 1 : 0;
      while (!done && l < 40) begin
         @(posedge clk);
         #1;
         l++;
         if (busy) bc++;
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      command = 4'd0;
      inputA  = 16'd0;
      inputB  = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy",   {31'd0, busy},  32'd0);
      chk("rst_done",   {31'd0, done},  32'd0);
      chk("rst_result", result,         32'd0);
      chk("rst_error",  {31'd0, error}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: MUL 255*127
      issue(4'd3, 16'd255, 16'd127);
      wait_done(lat, bcnt);
      chk("mul1_lat",    lat,             32'd17);
      chk("mul1_res",    result,          32'd32385);
      chk("mul1_err",    {31'd0, error},  32'd0);
      chk("mul1_busy",   bcnt,            32'd17);
      @(posedge clk); #1;
      chk("mul1_pulse",  {31'd0, done},   32'd0);
      chk("mul1_hold",   result,          32'd32385);

      // 2: MUL max*max
      issue(4'd3, 16'hFFFF, 16'hFFFF);
      wait_done(lat, bcnt);
      chk("mul2_res",    result,          32'hFFFE0001);
      chk("mul2_err",    {31'd0, error},  32'd0);

      // 3: DIV / MOD 1000 by 7
      issue(4'd4, 16'd1000, 16'd7);
      wait_done(lat, bcnt);
      chk("div_lat",     lat,             32'd17);
      chk("div_res",     result,          32'd142);
      chk("div_err",     {31'd0, error},  32'd0);
      issue(4'd5, 16'd1000, 16'd7);
      wait_done(lat, bcnt);
      chk("mod_lat",     lat,             32'd17);
      chk("mod_res",     result,          32'd6);
      chk("mod_err",     {31'd0, error},  32'd0);

      // 4: error paths
      issue(4'd4, 16'd50, 16'd0);
      wait_done(lat, bcnt);
      chk("div0_lat",    lat,             32'd1);
      chk("div0_res",    result,          32'hFFFFFFFF);
      chk("div0_err",    {31'd0, error},  32'd1);
      issue(4'd5, 16'd50, 16'd0);
      wait_done(lat, bcnt);
      chk("mod0_lat",    lat,             32'd1);
      chk("mod0_res",    result,          32'd50);
      chk("mod0_err",    {31'd0, error},  32'd1);
      issue(4'd6, 16'd9, 16'd3);
      wait_done(lat, bcnt);
      chk("inv_lat",     lat,             32'd1);
      chk("inv_res",     result,          32'd0);
      chk("inv_err",     {31'd0, error},  32'd1);

      // 5a: start while busy is ignored
      issue(4'd3, 16'd1234, 16'd100);
      repeat (4) begin @(posedge clk); #1; end
      issue(4'd3, 16'd3, 16'd3);
      wait_done(lat, bcnt);
      chk("ign_lat",     lat,             32'd12);
      chk("ign_res",     result,          32'd123400);

      // 5b: start in the done cycle is accepted and clears error
      issue(4'd4, 16'd50, 16'd0);
      wait_done(lat, bcnt);
      chk("b2b_pre_err", {31'd0, error},  32'd1);
      issue(4'd3, 16'd6, 16'd7);
      chk("b2b_err_clr", {31'd0, error},  32'd0);
      chk("b2b_busy",    {31'd0, busy},   32'd1);
      wait_done(lat, bcnt);
      chk("b2b_lat",     lat,             32'd17);
      chk("b2b_res",     result,          32'd42);

      // 6: asynchronous abort mid-DIV
      issue(4'd4, 16'd1000, 16'd7);
      repeat (8) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy",  {31'd0, busy},   32'd0);
      chk("abort_done",  {31'd0, done},   32'd0);
      chk("abort_res",   result,          32'd0);
      chk("abort_err",   {31'd0, error},  32'd0);
      repeat (12) begin
         @(posedge clk); #1;
         if (done) chk("abort_nodone", {31'd0, done}, 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      issue(4'd5, 16'd1000, 16'd7);
      wait_done(lat, bcnt);
      chk("post_lat",    lat,             32'd17);
      chk("post_res",    result,          32'd6);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
